// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt arbiter.
package irq_pkg;
    localparam int NIRQ   = 7;
    localparam int CODE_W = 3;
    localparam int PTR_W  = $clog2(NIRQ);

    localparam logic [CODE_W-1:0] CODE_NONE = '0;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        SERVICE
    } state_t;
endpackage

// File: rtl/irq_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or above
// rr_ptr, wrapping from NIRQ-1 back to 0.
module irq_rr_pick
    import irq_pkg::*;
(
    input  logic [NIRQ-1:0]  eligible,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             found,
    output logic [PTR_W-1:0] index
);
    logic [2*NIRQ-1:0] w_dbl;
    logic [NIRQ-1:0]   w_rot;
    logic [PTR_W-1:0]  w_off;
    logic [PTR_W:0]    w_sum;

    // Doubling the vector turns the wrap-around search into a plain window.
    assign w_dbl = {eligible, eligible};
    assign w_rot = w_dbl[rr_ptr +: NIRQ];

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the loop can leave it unassigned and infer a latch.
    always_comb begin
        found = 1'b0;
        w_off = '0;
        for (int k = NIRQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                found = 1'b1;
                w_off = PTR_W'(k);
            end
        end
    end

    assign w_sum = {1'b0, rr_ptr} + {1'b0, w_off};
    assign index = (w_sum >= (PTR_W + 1)'(NIRQ)) ? PTR_W'(w_sum - (PTR_W + 1)'(NIRQ))
                                                 : w_sum[PTR_W-1:0];
endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge-latched pending register, per-line mask,
// round-robin offer to the core and in-service tracking until end-of-interrupt.
module irq_arbiter
    import irq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NIRQ-1:0]   irq_in,
    input  logic              mask_we,
    input  logic [NIRQ-1:0]   mask_wdata,
    output logic [NIRQ-1:0]   mask,
    output logic              irq_valid,
    output logic [CODE_W-1:0] irq_code,
    input  logic              eirq,
    output logic              busy,
    input  logic              eoi,
    output logic [NIRQ-1:0]   pending,
    output logic [NIRQ-1:0]   overrun,
    input  logic              ovr_clr
);
    state_t           r_state;
    state_t           w_state_next;
    logic [NIRQ-1:0]  r_prev;
    logic [NIRQ-1:0]  r_pending;
    logic [NIRQ-1:0]  r_overrun;
    logic [NIRQ-1:0]  r_mask;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] r_grant;

    logic [NIRQ-1:0]  w_rise;
    logic [NIRQ-1:0]  w_clr;
    logic [NIRQ-1:0]  w_eligible;
    logic             w_found;
    logic [PTR_W-1:0] w_index;
    logic             w_load_offer;
    logic             w_accept;

    assign w_rise     = irq_in & ~r_prev;
    assign w_eligible = r_pending & ~r_mask;
    assign w_clr      = w_accept ? (NIRQ'(1) << r_grant) : '0;

    irq_rr_pick u_pick (
        .eligible (w_eligible),
        .rr_ptr   (r_rr_ptr),
        .found    (w_found),
        .index    (w_index)
    );

    always_comb begin
        w_state_next = r_state;
        w_load_offer = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next = OFFER;
                    w_load_offer = 1'b1;
                end
            end
            OFFER: begin
                if (eirq) begin
                    w_state_next = SERVICE;
                    w_accept     = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev    <= '0;
            r_pending <= '0;
            r_overrun <= '0;
            r_mask    <= '0;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
        end else begin
            r_prev <= irq_in;
            // A rise on the line being accepted re-arms it and is not an overrun.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_overrun <= (ovr_clr ? '0 : r_overrun) | (w_rise & r_pending & ~w_clr);
            if (mask_we) r_mask <= mask_wdata;
            if (w_load_offer) r_grant <= w_index;
            if (w_accept) begin
                r_rr_ptr <= (r_grant == PTR_W'(NIRQ - 1)) ? '0 : r_grant + 1'b1;
            end
        end
    end

    assign mask      = r_mask;
    assign pending   = r_pending;
    assign overrun   = r_overrun;
    assign irq_valid = (r_state == OFFER);
    assign busy      = (r_state == SERVICE);
    assign irq_code  = irq_valid ? CODE_W'(r_grant) + 1'b1 : CODE_NONE;
endmodule

// File: tb/tb_irq_arbiter.sv
// Directed self-checking bench for irq_arbiter: single request, round-robin,
// mask, overrun/set-wins, level hold and asynchronous reset.
module tb_irq_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] irq_in = '0;
    logic       mask_we = 1'b0;
    logic [6:0] mask_wdata = '0;
    logic [6:0] mask;
    logic       irq_valid;
    logic [2:0] irq_code;
    logic       eirq = 1'b0;
    logic       busy;
    logic       eoi = 1'b0;
    logic [6:0] pending;
    logic [6:0] overrun;
    logic       ovr_clr = 1'b0;

    int errors = 0;
    int checks = 0;
    int dispatches;

    irq_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .irq_valid  (irq_valid),
        .irq_code   (irq_code),
        .eirq       (eirq),
        .busy       (busy),
        .eoi        (eoi),
        .pending    (pending),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One active edge; returns at the following falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
        eirq = 1'b0; eoi = 1'b0; ovr_clr = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".mask"},    32'(mask),      32'h0);
        check({tag, ".pending"}, 32'(pending),   32'h0);
        check({tag, ".overrun"}, 32'(overrun),   32'h0);
        check({tag, ".valid"},   32'(irq_valid), 32'h0);
        check({tag, ".code"},    32'(irq_code),  32'h0);
        check({tag, ".busy"},    32'(busy),      32'h0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        do_reset();
        check_all_zero("reset");

        // Single request on line 2
        irq_in = 7'b0000100;
        tick();
        check("single.pending_e0", 32'(pending), 32'h04);
        check("single.valid_e0",   32'(irq_valid), 32'h0);
        tick();
        check("single.valid_e1", 32'(irq_valid), 32'h1);
        check("single.code_e1",  32'(irq_code),  32'h3);
        tick();
        check("single.code_e2", 32'(irq_code), 32'h3);
        eirq = 1'b1;
        tick();
        eirq = 1'b0;
        check("single.pending_acc", 32'(pending),   32'h0);
        check("single.busy_acc",    32'(busy),      32'h1);
        check("single.code_acc",    32'(irq_code),  32'h0);
        check("single.valid_acc",   32'(irq_valid), 32'h0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check("single.busy_eoi", 32'(busy), 32'h0);

        // Round-robin between lines 0 and 1
        do_reset();
        irq_in = 7'b0000011;
        tick();
        check("rr.pending", 32'(pending), 32'h03);
        tick();
        check("rr.code_first", 32'(irq_code), 32'h1);
        eirq = 1'b1;
        tick();
        eirq = 1'b0;
        check("rr.pending_after1", 32'(pending), 32'h02);
        irq_in = 7'b0000010;
        tick();
        irq_in = 7'b0000011;
        tick();
        check("rr.pending_relatch", 32'(pending), 32'h03);
        check("rr.busy_hold",       32'(busy),    32'h1);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        check("rr.code_second", 32'(irq_code), 32'h2);
        eirq = 1'b1;
        tick();
        eirq = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        check("rr.code_third", 32'(irq_code), 32'h1);
        eirq = 1'b1;
        tick();
        eirq = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        irq_in = '0;
        tick();
        check("rr.idle_empty", 32'(irq_valid), 32'h0);
        // Pointer now sits at 1, so a simultaneous 0/1 request must pick line 1.
        irq_in = 7'b0000011;
        tick();
        tick();
        check("rr.ptr_after", 32'(irq_code), 32'h2);

        // Mask blocks selection but not latching
        do_reset();
        mask_we = 1'b1; mask_wdata = 7'b0010000;
        tick();
        mask_we = 1'b0;
        check("mask.reg", 32'(mask), 32'h10);
        irq_in = 7'b0010000;
        tick();
        check("mask.pending", 32'(pending), 32'h10);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mask.blocked", 32'(irq_valid), 32'h0);
        end
        mask_we = 1'b1; mask_wdata = 7'b0000000;
        tick();
        mask_we = 1'b0;
        check("mask.write_edge_valid", 32'(irq_valid), 32'h0);
        tick();
        check("mask.unmask_valid", 32'(irq_valid), 32'h1);
        check("mask.unmask_code",  32'(irq_code),  32'h5);
        mask_we = 1'b1; mask_wdata = 7'b1111111;
        tick();
        mask_we = 1'b0;
        check("mask.no_withdraw", 32'(irq_valid), 32'h1);
        check("mask.held_code",   32'(irq_code),  32'h5);

        // Overrun on line 5 and set-wins on line 3
        do_reset();
        irq_in = 7'b0100000;
        tick();
        irq_in = 7'b0000000;
        tick();
        check("ovr.offer_code", 32'(irq_code), 32'h6);
        irq_in = 7'b0100000;
        tick();
        check("ovr.flag",    32'(overrun), 32'h20);
        check("ovr.pending", 32'(pending), 32'h20);
        eirq = 1'b1;
        tick();
        eirq = 1'b0;
        check("ovr.pending_acc", 32'(pending), 32'h0);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        check("ovr.single_dispatch", 32'(irq_valid), 32'h0);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr.clear", 32'(overrun), 32'h0);
        irq_in = 7'b0001000;
        tick();
        tick();
        check("sw.offer_code", 32'(irq_code), 32'h4);
        irq_in = 7'b0000000;
        tick();
        irq_in = 7'b0001000;
        eirq = 1'b1;
        tick();
        eirq = 1'b0;
        check("sw.pending_kept", 32'(pending), 32'h08);
        check("sw.no_overrun",   32'(overrun), 32'h0);
        check("sw.busy",         32'(busy),    32'h1);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        tick();
        check("sw.reoffer_code", 32'(irq_code), 32'h4);

        // Level held high dispatches once
        do_reset();
        dispatches = 0;
        irq_in = 7'b1000000;
        for (int i = 0; i < 50; i++) begin
            if (irq_valid && irq_code == 3'd7) dispatches++;
            eirq = irq_valid;
            eoi  = busy;
            tick();
        end
        eirq = 1'b0;
        eoi  = 1'b0;
        irq_in = '0;
        check("level.dispatches", 32'(dispatches), 32'd1);
        check("level.pending",    32'(pending),    32'h0);

        // Asynchronous reset during service
        do_reset();
        irq_in = 7'b1000001;
        tick();
        tick();
        check("arst.offer_code", 32'(irq_code), 32'h1);
        eirq = 1'b1;
        tick();
        eirq = 1'b0;
        irq_in = 7'b1000000;
        tick();
        irq_in = 7'b1000001;
        tick();
        check("arst.pending_pre", 32'(pending), 32'h41);
        check("arst.busy_pre",    32'(busy),    32'h1);
        rst = 1'b1;
        irq_in = '0;
        #1;
        check_all_zero("arst.immediate");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("arst.no_replay_valid",   32'(irq_valid), 32'h0);
        check("arst.no_replay_pending", 32'(pending),   32'h0);
        irq_in = 7'b1000000;
        tick();
        tick();
        check("arst.new_edge_code", 32'(irq_code), 32'h7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
